ps2_rx_frame: RTL and testbench

Parametrised PS/2 device-to-host receiver for the ps2 subsystem, the generalised successor of the plain serial-to-parallel shift register. It synchronises and de-glitches the raw PS/2 clock and data lines, and frames start/data/parity/stop bits with a state machine. Good bytes are pushed into a small FIFO that downstream logic drains with a valid/read-enable handshake. Framing errors, timeouts and overflow are reported as single-cycle pulses.

---
 rtl/ps2_rx_frame_if.sv | 27 ++
 rtl/ps2_rx_frame.sv | 166 ++++++++++++++++
 tb/tb_ps2_rx_frame.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_rx_frame_if.sv
// Bundle of PS/2 pin inputs and byte-FIFO read-side signals for ps2_rx_frame.
// master = the receiver (drives the FIFO side), slave = its user (drives pins and rd_en).
interface ps2_rx_frame_if #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
);
  localparam int FILL_W = $clog2(FIFO_DEPTH + 1);

  logic              ps2_clk_in;
  logic              ps2_data_in;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic [FILL_W-1:0] fill;
  logic              frame_err;
  logic              overflow;

  modport master (
    input  ps2_clk_in, ps2_data_in, rd_en,
    output rd_data, rd_valid, fill, frame_err, overflow
  );

  modport slave (
    output ps2_clk_in, ps2_data_in, rd_en,
    input  rd_data, rd_valid, fill, frame_err, overflow
  );
endinterface

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host receiver: synchroniser, clock de-glitch filter, framing FSM, byte FIFO.
// Optional odd-parity enforcement is enabled by defining PS2_RX_PARITY_CHECK_EN.
module ps2_rx_frame #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 5000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic             clk,
  input  logic             reset,
  ps2_rx_frame_if.master   bus
);
  localparam int FILL_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int TMO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_e;

  // ---------------- synchronise and filter ----------------
  logic [SYNC_STAGES-1:0] sclk_q, sdat_q;
  logic [FILTER_LEN-2:0]  hist_q;
  logic [FILTER_LEN-1:0]  dly_q;
  logic [FILTER_LEN-1:0]  window;
  logic                   filt_q, filt_d, fall_q;
  logic                   d_bit;

  // window = the last FILTER_LEN synced clock samples, newest in bit 0
  assign window = {hist_q, sclk_q[SYNC_STAGES-1]};
  assign d_bit  = dly_q[FILTER_LEN-1];

  always_comb begin
    filt_d = filt_q;
    if (&window)       filt_d = 1'b1;
    else if (~|window) filt_d = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_q <= '1;
      sdat_q <= '1;
      hist_q <= '1;
      dly_q  <= '1;
      filt_q <= 1'b1;
      fall_q <= 1'b0;
    end else begin
      sclk_q <= {sclk_q[SYNC_STAGES-2:0], bus.ps2_clk_in};
      sdat_q <= {sdat_q[SYNC_STAGES-2:0], bus.ps2_data_in};
      hist_q <= window[FILTER_LEN-2:0];
      dly_q  <= {dly_q[FILTER_LEN-2:0], sdat_q[SYNC_STAGES-1]};
      filt_q <= filt_d;
      fall_q <= filt_q & ~filt_d;
    end
  end

  // ---------------- framing FSM ----------------
  state_e            state_q, state_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              par_q, par_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              parity_ok, push_req, err_d;

`ifdef PS2_RX_PARITY_CHECK_EN
  assign parity_ok = ^{sh_q, par_q};
`else
  assign parity_ok = 1'b1;
`endif

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    sh_d     = sh_q;
    cnt_d    = cnt_q;
    par_d    = par_q;
    tmo_d    = tmo_q + 1'b1;
    push_req = 1'b0;
    err_d    = 1'b0;
    if (state_q == S_IDLE || fall_q) tmo_d = '0;
    if (fall_q) begin
      case (state_q)
        S_IDLE: if (!d_bit) begin
          state_d = S_DATA;
          cnt_d   = '0;
        end
        S_DATA: begin
          sh_d  = DATA_W'({d_bit, sh_q} >> 1);
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(DATA_W - 1)) state_d = S_PARITY;
        end
        S_PARITY: begin
          par_d   = d_bit;
          state_d = S_STOP;
        end
        default: begin
          if (d_bit && parity_ok) push_req = 1'b1;
          else                    err_d    = 1'b1;
          state_d = S_IDLE;
        end
      endcase
    end else if (state_q != S_IDLE && tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
      // a fall in this same cycle would have taken the branch above instead
      state_d = S_IDLE;
      tmo_d   = '0;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      tmo_q   <= tmo_d;
    end
  end

  // ---------------- byte FIFO ----------------
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [FILL_W-1:0] fill_q;
  logic              pop, push, err_q, ovf_q;

  assign pop  = bus.rd_en && (fill_q != '0);
  assign push = push_req && ((fill_q != FILL_W'(FIFO_DEPTH)) || pop);

  // NOTE: storage is not reset; pointers and fill define validity, and rd_data is gated when empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= sh_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   fill_q <= fill_q + 1'b1;
        2'b01:   fill_q <= fill_q - 1'b1;
        default: fill_q <= fill_q;
      endcase
      err_q <= err_d;
      ovf_q <= push_req && !push;
    end
  end

  assign bus.rd_valid  = (fill_q != '0);
  assign bus.rd_data   = (fill_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign bus.fill      = fill_q;
  assign bus.frame_err = err_q;
  assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_ps2_rx_frame.sv
// Self-checking bench for ps2_rx_frame: table vectors, hand-written corner sequences,
// and random frames against a queue-based model of the byte stream.
module tb_ps2_rx_frame;
  localparam int T      = 200;
  localparam int SYNC   = 2;
  localparam int FILT   = 4;
  localparam int DEPTH  = 4;
  localparam int HALF   = 20;
  localparam int QTR    = 10;

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   err_seen = 0, ovf_seen = 0, err_cyc = 0;
  int   last_low_cyc = 0;
  logic prev_err = 0, prev_ovf = 0;
  logic [7:0] q[$];

  ps2_rx_frame_if #(.DATA_W(8), .FIFO_DEPTH(DEPTH)) bus ();

  ps2_rx_frame #(
    .DATA_W(8), .SYNC_STAGES(SYNC), .FILTER_LEN(FILT),
    .TIMEOUT_CYC(T), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Pulse monitor: counts pulses and confirms each lasts one cycle.
  always @(negedge clk) begin
    if (bus.frame_err === 1'b1) begin
      check("frame_err_one_cycle", prev_err, 1'b0);
      err_seen++;
      err_cyc = cyc;
    end
    if (bus.overflow === 1'b1) begin
      check("overflow_one_cycle", prev_ovf, 1'b0);
      ovf_seen++;
    end
    prev_err = bus.frame_err;
    prev_ovf = bus.overflow;
  end

  function automatic logic odd_par(input logic [7:0] d);
    return ($countones(d) % 2 == 0);
  endfunction

  function automatic bit frame_good(input logic [7:0] d, input logic p, input logic s);
`ifdef PS2_RX_PARITY_CHECK_EN
    return s && (($countones(d) + p) % 2 == 1);
`else
    return s;
`endif
  endfunction

  // Device-side frame: start, DATA LSB first, parity, stop; only the first nbits are sent.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input int nbits);
    logic [10:0] bits;
    bits = {s, p, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      bus.ps2_data_in = bits[i];
      repeat (QTR) @(negedge clk);
      bus.ps2_clk_in = 1'b0;
      last_low_cyc = cyc;
      repeat (HALF) @(negedge clk);
      bus.ps2_clk_in = 1'b1;
      repeat (QTR) @(negedge clk);
    end
    bus.ps2_data_in = 1'b1;
  endtask

  task automatic pop_check(input string name, input logic [7:0] exp);
    check({name, "_valid"}, bus.rd_valid, 1'b1);
    check({name, "_data"}, bus.rd_data, exp);
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
    bit         err_chk;
    bit         err_nochk;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int e0, o0, exp_err, k;
    logic [7:0] d;
    logic p, s;
    bit good;

    tbl[0] = '{8'h1C, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{8'hF0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{8'h55, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{8'hFF, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{8'h80, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{8'h3C, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[7] = '{8'hA5, 1'b0, 1'b1, 1'b1, 1'b0};

    bus.ps2_clk_in  = 1'b1;
    bus.ps2_data_in = 1'b1;
    bus.rd_en       = 1'b0;
    reset           = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_rd_valid", bus.rd_valid, 1'b0);
    check("reset_rd_data", bus.rd_data, 8'h00);
    check("reset_fill", bus.fill, 3'd0);
    check("reset_frame_err", bus.frame_err, 1'b0);
    check("reset_overflow", bus.overflow, 1'b0);

    // ---- table vectors ----
    for (int i = 0; i < 8; i++) begin
`ifdef PS2_RX_PARITY_CHECK_EN
      exp_err = tbl[i].err_chk;
`else
      exp_err = tbl[i].err_nochk;
`endif
      e0 = err_seen; o0 = ovf_seen;
      send_frame(tbl[i].data, tbl[i].par, tbl[i].stop, 11);
      check($sformatf("tbl%0d_err", i), err_seen - e0, exp_err);
      check($sformatf("tbl%0d_ovf", i), ovf_seen - o0, 0);
      check($sformatf("tbl%0d_fill", i), bus.fill, exp_err ? 0 : 1);
      if (!exp_err) begin
        pop_check($sformatf("tbl%0d", i), tbl[i].data);
        check($sformatf("tbl%0d_empty", i), bus.rd_valid, 1'b0);
      end
    end

    // ---- overflow: five good bytes, no reads ----
    e0 = err_seen; o0 = ovf_seen;
    for (int i = 1; i <= 4; i++) send_frame(8'(i), odd_par(8'(i)), 1'b1, 11);
    check("ovf_fill_full", bus.fill, 3'd4);
    check("ovf_none_yet", ovf_seen - o0, 0);
    send_frame(8'h05, odd_par(8'h05), 1'b1, 11);
    check("ovf_pulse", ovf_seen - o0, 1);
    check("ovf_fill_still_full", bus.fill, 3'd4);
    check("ovf_no_err", err_seen - e0, 0);
    for (int i = 1; i <= 4; i++) pop_check($sformatf("ovf_read%0d", i), 8'(i));
    check("ovf_drained", bus.rd_valid, 1'b0);

    // ---- timeout after four data bits ----
    e0 = err_seen;
    send_frame(8'h0F, 1'b1, 1'b1, 5);
    for (int i = 0; i < T + 100 && err_seen == e0; i++) @(negedge clk);
    check("tmo_pulse", err_seen - e0, 1);
    check("tmo_latency", err_cyc - last_low_cyc, T + SYNC + FILT + 1);
    check("tmo_fill", bus.fill, 3'd0);
    send_frame(8'hAA, 1'b1, 1'b1, 11);
    check("tmo_recover_fill", bus.fill, 3'd1);
    pop_check("tmo_recover", 8'hAA);

    // ---- short clock glitches with data low ----
    e0 = err_seen;
    bus.ps2_data_in = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.ps2_clk_in = 1'b0;
      repeat (2) @(negedge clk);
      bus.ps2_clk_in = 1'b1;
      repeat (10) @(negedge clk);
    end
    bus.ps2_data_in = 1'b1;
    repeat (T + 50) @(negedge clk);
    check("glitch_no_err", err_seen - e0, 0);
    check("glitch_fill", bus.fill, 3'd0);
    send_frame(8'h1C, 1'b0, 1'b1, 11);
    check("glitch_after_fill", bus.fill, 3'd1);
    pop_check("glitch_after", 8'h1C);

    // ---- reset mid-frame ----
    send_frame(8'h55, 1'b1, 1'b1, 11);
    check("rst_pre_fill", bus.fill, 3'd1);
    send_frame(8'h33, 1'b1, 1'b1, 5);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_rd_valid", bus.rd_valid, 1'b0);
    check("rst_rd_data", bus.rd_data, 8'h00);
    check("rst_fill", bus.fill, 3'd0);
    check("rst_frame_err", bus.frame_err, 1'b0);
    check("rst_overflow", bus.overflow, 1'b0);
    e0 = err_seen;
    repeat (T + 50) @(negedge clk);
    check("rst_no_tmo", err_seen - e0, 0);
    send_frame(8'hAA, 1'b1, 1'b1, 11);
    check("rst_after_fill", bus.fill, 3'd1);
    pop_check("rst_after", 8'hAA);

    // ---- random frames against the queue model ----
    q.delete();
    for (int n = 0; n < 40; n++) begin
      k = $urandom_range(0, q.size());
      for (int j = 0; j < k; j++) pop_check($sformatf("rnd%0d_pop", n), q.pop_front());
      d = 8'($urandom);
      p = ($urandom_range(0, 4) == 0) ? ~odd_par(d) : odd_par(d);
      s = ($urandom_range(0, 9) != 0);
      good = frame_good(d, p, s);
      e0 = err_seen; o0 = ovf_seen;
      send_frame(d, p, s, 11);
      check($sformatf("rnd%0d_err", n), err_seen - e0, good ? 0 : 1);
      if (good && q.size() == DEPTH) begin
        check($sformatf("rnd%0d_ovf", n), ovf_seen - o0, 1);
      end else begin
        check($sformatf("rnd%0d_ovf", n), ovf_seen - o0, 0);
        if (good) q.push_back(d);
      end
      check($sformatf("rnd%0d_fill", n), bus.fill, q.size());
      if (q.size() > 0) check($sformatf("rnd%0d_head", n), bus.rd_data, q[0]);
    end
    while (q.size() > 0) pop_check("rnd_drain", q.pop_front());
    check("rnd_empty", bus.rd_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
